// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute sequencer for the 8-bit
// processor. Owns PC, IR and OPR, steps the memory port through each
// instruction class reported by the external decoder, and handles wait-states,
// halt/resume, memory timeout and illegal-instruction faults.
module control_sequencer #(
  parameter int PC_WIDTH = 4,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic                mem_req,
  output logic                mem_we,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic                mem_ready,
  input  logic [7:0]          mem_rdata,
  output logic [7:0]          opcode,
  output logic [7:0]          operand,
  input  logic [1:0]          dec_kind,
  input  logic                dec_two_byte,
  input  logic                dec_halt,
  input  logic [3:0]          dec_dest_flag,
  output logic [3:0]          reg_we,
  output logic                wb_src,
  output logic [7:0]          ld_data,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [1:0] K_ALU   = 2'b00;
  localparam logic [1:0] K_LOAD  = 2'b01;
  localparam logic [1:0] K_STORE = 2'b10;
  localparam logic [1:0] K_JUMP  = 2'b11;

  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

  // Counter must hold TIMEOUT-1; TIMEOUT >= 1 keeps CW >= 1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

  state_t          state, nxt;
  logic [7:0]      ir, opr;
  logic            run_q;
  logic [CW-1:0]   wait_cnt;
  logic            run_rise;
  logic            in_mem;
  logic            timeout;
  logic [1:0]      nxt_code;

  assign run_rise = run & ~run_q;
  assign in_mem   = (state == S_FETCH) || (state == S_OPERAND) || (state == S_MEM);
  // The TIMEOUT-th consecutive wait cycle is ending without a ready.
  assign timeout  = in_mem && !mem_ready && (wait_cnt == WAIT_LAST);

  assign opcode   = ir;
  assign operand  = opr;
  // Only the data access uses the operand as an address; everything else is PC.
  assign mem_addr = (state == S_MEM) ? opr[PC_WIDTH-1:0] : pc;

  // Next-state selection; outputs below are registered from nxt so they are
  // glitch-free and line up with the state they belong to.
  always_comb begin
    nxt      = state;
    nxt_code = fault_code;
    case (state)
      S_IDLE:   if (run_rise) nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    nxt = S_DECODE;
        else if (timeout) begin nxt = S_FAULT; nxt_code = FC_TIMEOUT; end
      end
      S_DECODE: begin
        if (dec_halt)                                  nxt = S_HALT;
        else if (dec_kind != K_ALU && !dec_two_byte) begin
          nxt = S_FAULT; nxt_code = FC_ILLEGAL;
        end
        else if (dec_two_byte)                         nxt = S_OPERAND;
        else                                           nxt = S_WB;
      end
      S_OPERAND: begin
        if (mem_ready) begin
          case (dec_kind)
            K_ALU:   nxt = S_WB;
            K_JUMP:  nxt = S_FETCH;
            default: nxt = S_MEM;
          endcase
        end
        else if (timeout) begin nxt = S_FAULT; nxt_code = FC_TIMEOUT; end
      end
      S_MEM: begin
        if (mem_ready)    nxt = (dec_kind == K_LOAD) ? S_WB : S_FETCH;
        else if (timeout) begin nxt = S_FAULT; nxt_code = FC_TIMEOUT; end
      end
      S_WB:     nxt = S_FETCH;
      S_HALT:   if (run_rise) nxt = S_FETCH;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
  end

  // Sequencer state, architectural registers and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= PC_INIT;
      ir         <= '0;
      opr        <= '0;
      ld_data    <= '0;
      run_q      <= 1'b0;
      wait_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      reg_we     <= '0;
      wb_src     <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= '0;
    end else begin
      state      <= nxt;
      run_q      <= run;
      fault_code <= nxt_code;

      // Wait counter: zero outside memory states (so every entry starts at 0)
      // and on each completed access; counts only unanswered request cycles.
      if (!in_mem || mem_ready) wait_cnt <= '0;
      else                      wait_cnt <= wait_cnt + CW'(1);

      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + PC_ONE;
        end
        S_OPERAND: if (mem_ready) begin
          opr <= mem_rdata;
          pc  <= (dec_kind == K_JUMP) ? mem_rdata[PC_WIDTH-1:0] : pc + PC_ONE;
        end
        S_MEM: if (mem_ready && dec_kind == K_LOAD) ld_data <= mem_rdata;
        default: ;
      endcase

      mem_req <= (nxt == S_FETCH) || (nxt == S_OPERAND) || (nxt == S_MEM);
      mem_we  <= (nxt == S_MEM) && (dec_kind == K_STORE);
      reg_we  <= (nxt == S_WB) ? dec_dest_flag : 4'b0000;
      wb_src  <= (nxt == S_WB) && (dec_kind == K_LOAD);
      busy    <= !((nxt == S_IDLE) || (nxt == S_HALT) || (nxt == S_FAULT));
      halted  <= (nxt == S_HALT);
      fault   <= (nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: small memory model with per-address
// wait-states and a stand-in opcode decoder.
module tb_control_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       mem_req, mem_we, mem_ready;
  logic [3:0] mem_addr, pc;
  logic [7:0] mem_rdata, opcode, operand, ld_data;
  logic [1:0] dec_kind, fault_code;
  logic       dec_two_byte, dec_halt;
  logic [3:0] dec_dest_flag, reg_we;
  logic       wb_src, busy, halted, fault;

  int checks = 0;
  int passes = 0;

  logic [7:0] mem [16];
  logic       hold_low = 1'b0;
  logic [3:0] stall_addr = 4'd0;
  int         stall_n = 0;
  int         wcnt = 0;
  int         we_pulses = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .opcode(opcode), .operand(operand),
    .dec_kind(dec_kind), .dec_two_byte(dec_two_byte), .dec_halt(dec_halt),
    .dec_dest_flag(dec_dest_flag),
    .reg_we(reg_we), .wb_src(wb_src), .ld_data(ld_data), .pc(pc),
    .busy(busy), .halted(halted), .fault(fault), .fault_code(fault_code)
  );

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = mem_req && !hold_low &&
                     ((mem_addr != stall_addr) || (wcnt >= stall_n));

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
    if (mem_we) we_pulses <= we_pulses + 1;
  end

  // Opcode map: 00 NOP, 01 MOV_A_B, 10 LOAD B, 20 STORE, 21 bad STORE,
  // 30 JUMP, FF HALT.
  always_comb begin
    dec_kind = 2'b00; dec_two_byte = 1'b0; dec_halt = 1'b0; dec_dest_flag = 4'b0000;
    case (opcode)
      8'h01: dec_dest_flag = 4'b0001;
      8'h10: begin dec_kind = 2'b01; dec_two_byte = 1'b1; dec_dest_flag = 4'b0010; end
      8'h20: begin dec_kind = 2'b10; dec_two_byte = 1'b1; end
      8'h21: dec_kind = 2'b10;
      8'h30: begin dec_kind = 2'b11; dec_two_byte = 1'b1; end
      8'hFF: dec_halt = 1'b1;
      default: ;
    endcase
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    hold_low = 1'b0; stall_n = 0; stall_addr = 4'd0;
  endtask

  task automatic do_reset;
    rst = 1'b1; run = 1'b0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic run_pulse;
    run = 1'b1; tick; run = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %b want 0", mem_req); else passes++;
    checks++; if (pc !== 4'd0) $display("FAIL rst_pc got %0h want 0", pc); else passes++;
    checks++; if (busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0)
      $display("FAIL rst_status got %b%b%b want 000", busy, halted, fault); else passes++;
    checks++; if (opcode !== 8'h00 || operand !== 8'h00 || ld_data !== 8'h00)
      $display("FAIL rst_regs got %h %h %h want 00 00 00", opcode, operand, ld_data); else passes++;
    checks++; if (reg_we !== 4'b0000 || mem_we !== 1'b0 || mem_addr !== 4'd0)
      $display("FAIL rst_ctrl got %b %b %h want 0000 0 0", reg_we, mem_we, mem_addr); else passes++;
  endtask

  task automatic test_mov;
    clear_mem; mem[0] = 8'h01; mem[1] = 8'hFF;
    do_reset;
    run_pulse;  // FETCH @0
    checks++; if (mem_req !== 1'b1 || mem_addr !== 4'd0 || busy !== 1'b1)
      $display("FAIL mov_fetch got req=%b addr=%h busy=%b want 1 0 1", mem_req, mem_addr, busy); else passes++;
    tick;       // DECODE
    checks++; if (opcode !== 8'h01 || pc !== 4'd1 || mem_req !== 1'b0)
      $display("FAIL mov_decode got op=%h pc=%h req=%b want 01 1 0", opcode, pc, mem_req); else passes++;
    tick;       // WB
    checks++; if (reg_we !== 4'b0001 || wb_src !== 1'b0)
      $display("FAIL mov_wb got we=%b src=%b want 0001 0", reg_we, wb_src); else passes++;
    tick;       // FETCH @1, fourth cycle
    checks++; if (reg_we !== 4'b0000 || mem_req !== 1'b1 || mem_addr !== 4'd1)
      $display("FAIL mov_next got we=%b req=%b addr=%h want 0000 1 1", reg_we, mem_req, mem_addr); else passes++;
    tick; tick; // DECODE HALT -> HALT
    checks++; if (halted !== 1'b1 || pc !== 4'd2 || busy !== 1'b0)
      $display("FAIL mov_halt got h=%b pc=%h busy=%b want 1 2 0", halted, pc, busy); else passes++;
  endtask

  task automatic test_load;
    int cyc;
    clear_mem; mem[0] = 8'h10; mem[1] = 8'h0A; mem[10] = 8'h5C; mem[2] = 8'hFF;
    stall_addr = 4'd10; stall_n = 2;
    do_reset;
    run_pulse;  // cycle 1 = FETCH
    cyc = 1;
    while (reg_we === 4'b0000 && cyc < 30) begin tick; cyc++; end
    checks++; if (cyc != 7) $display("FAIL load_cycles got %0d want 7", cyc); else passes++;
    checks++; if (reg_we !== 4'b0010 || wb_src !== 1'b1)
      $display("FAIL load_wb got we=%b src=%b want 0010 1", reg_we, wb_src); else passes++;
    checks++; if (ld_data !== 8'h5C || operand !== 8'h0A)
      $display("FAIL load_data got ld=%h opr=%h want 5c 0a", ld_data, operand); else passes++;
    tick;
    checks++; if (reg_we !== 4'b0000 || mem_addr !== 4'd2 || mem_req !== 1'b1)
      $display("FAIL load_after got we=%b addr=%h req=%b want 0000 2 1", reg_we, mem_addr, mem_req); else passes++;
  endtask

  task automatic test_store_back_to_back;
    clear_mem; mem[0] = 8'h20; mem[1] = 8'h09; mem[2] = 8'hFF;
    do_reset;
    run_pulse; tick; tick; tick;  // FETCH, DECODE, OPERAND, MEM
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd9)
      $display("FAIL store_mem got req=%b we=%b addr=%h want 1 1 9", mem_req, mem_we, mem_addr); else passes++;
    tick;                         // FETCH @2 with no gap
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd2)
      $display("FAIL store_next got req=%b we=%b addr=%h want 1 0 2", mem_req, mem_we, mem_addr); else passes++;
  endtask

  task automatic test_jump_wrap;
    clear_mem; mem[0] = 8'h30; mem[1] = 8'h0E; mem[14] = 8'h30; mem[15] = 8'h03; mem[3] = 8'hFF;
    do_reset;
    run_pulse; tick; tick; tick;  // back in FETCH at target
    checks++; if (pc !== 4'd14 || mem_addr !== 4'd14)
      $display("FAIL jump1_pc got pc=%h addr=%h want e e", pc, mem_addr); else passes++;
    tick; tick; tick;
    checks++; if (pc !== 4'd3 || mem_addr !== 4'd3)
      $display("FAIL jump2_pc got pc=%h addr=%h want 3 3", pc, mem_addr); else passes++;
    clear_mem; mem[0] = 8'h30; mem[1] = 8'h0F; mem[15] = 8'h00;
    do_reset;
    run_pulse; tick; tick; tick;  // FETCH @15
    checks++; if (mem_addr !== 4'd15) $display("FAIL wrap_fetch got %h want f", mem_addr); else passes++;
    tick;                         // DECODE: pc wrapped
    checks++; if (pc !== 4'd0) $display("FAIL wrap_pc got %h want 0", pc); else passes++;
  endtask

  task automatic test_timeout;
    int n;
    clear_mem; hold_low = 1'b1;
    do_reset;
    run_pulse;  // entered FETCH
    n = 0;
    while (fault !== 1'b1 && n < 40) begin tick; n++; end
    checks++; if (n != 15) $display("FAIL timeout_cycles got %0d want 15", n); else passes++;
    checks++; if (fault_code !== 2'b01 || busy !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL timeout_state got code=%b busy=%b req=%b want 01 0 0", fault_code, busy, mem_req); else passes++;
    run_pulse; tick; run_pulse; tick;
    checks++; if (fault !== 1'b1 || mem_req !== 1'b0 || fault_code !== 2'b01)
      $display("FAIL timeout_sticky got f=%b req=%b code=%b want 1 0 01", fault, mem_req, fault_code); else passes++;
    hold_low = 1'b0;
    do_reset;
    checks++; if (fault !== 1'b0 || fault_code !== 2'b00)
      $display("FAIL timeout_clear got f=%b code=%b want 0 00", fault, fault_code); else passes++;
  endtask

  task automatic test_halt;
    int n;
    clear_mem; mem[2] = 8'hFF; mem[3] = 8'h01;
    do_reset;
    run = 1'b1;
    n = 0;
    while (halted !== 1'b1 && n < 40) begin tick; n++; end
    checks++; if (halted !== 1'b1 || pc !== 4'd3)
      $display("FAIL halt_enter got h=%b pc=%h want 1 3", halted, pc); else passes++;
    tick; tick; tick;
    checks++; if (halted !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL halt_hold got h=%b req=%b want 1 0", halted, mem_req); else passes++;
    run = 1'b0; tick;
    run = 1'b1; tick;
    checks++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 4'd3)
      $display("FAIL halt_resume got h=%b req=%b addr=%h want 0 1 3", halted, mem_req, mem_addr); else passes++;
    run = 1'b0;
  endtask

  task automatic test_illegal;
    int n, w0;
    clear_mem; mem[0] = 8'h21;
    do_reset;
    w0 = we_pulses;
    run_pulse;
    n = 0;
    while (fault !== 1'b1 && n < 40) begin
      checks++; if (reg_we !== 4'b0000) $display("FAIL illegal_regwe got %b want 0000", reg_we); else passes++;
      tick; n++;
    end
    checks++; if (fault !== 1'b1 || fault_code !== 2'b10 || n != 2)
      $display("FAIL illegal_fault got f=%b code=%b cyc=%0d want 1 10 2", fault, fault_code, n); else passes++;
    checks++; if (we_pulses != w0) $display("FAIL illegal_we got %0d want 0", we_pulses - w0); else passes++;
  endtask

  task automatic test_rst_mid;
    clear_mem; hold_low = 1'b1;
    do_reset;
    run_pulse; tick; tick;
    checks++; if (mem_req !== 1'b1) $display("FAIL midrst_pre got %b want 1", mem_req); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || reg_we !== 4'b0000 || busy !== 1'b0)
      $display("FAIL midrst_drop got req=%b we=%b rwe=%b busy=%b want 0 0 0000 0", mem_req, mem_we, reg_we, busy); else passes++;
    tick; rst = 1'b0; hold_low = 1'b0; tick; tick;
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || pc !== 4'd0)
      $display("FAIL midrst_idle got busy=%b req=%b pc=%h want 0 0 0", busy, mem_req, pc); else passes++;
  endtask

  initial begin
    clear_mem;
    test_reset;
    test_mov;
    test_load;
    test_store_back_to_back;
    test_jump_wrap;
    test_timeout;
    test_halt;
    test_illegal;
    test_rst_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit processor. Owns the program counter (PC), instruction register (IR) and operand register (OPR), and drives the opcode into the combinational decoder. It uses the decoder's instruction class to step the memory port and the register-bank write enables through each instruction. It also handles memory wait-states, halt/resume, and illegal-instruction and timeout faults.

## Interface
- PC_WIDTH, 4, width of the PC and the memory address.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, maximum consecutive wait cycles (mem_ready low) before a fault; must be ≥1.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  start/resume request; acted on only on a rising edge.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; 1 only for the STORE data access.
- mem_addr  out  PC_WIDTH  address: PC in FETCH/OPERAND; OPR[PC_WIDTH-1:0] in MEM; PC otherwise.
- mem_ready  in  1  access complete this cycle; sampled only while mem_req=1.
- mem_rdata  in  8  read data, valid when mem_ready=1.
- opcode  out  8  IR contents, driven to the decoder.
- operand  out  8  OPR contents; also the STORE address/immediate source for the datapath.
- dec_kind  in  2  class from the decoder: 00 ALU/MOV, 01 LOAD, 10 STORE, 11 JUMP.
- dec_two_byte  in  1  instruction carries an operand byte.
- dec_halt  in  1  HALT instruction.
- dec_dest_flag  in  4  one-hot destination register (A,B,C,D).
- reg_we  out  4  register write enables; one-cycle pulse.
- wb_src  out  1  writeback source: 1 = ld_data, 0 = ALU.
- ld_data  out  8  latched LOAD data.
- pc  out  PC_WIDTH  current PC.
- busy  out  1  high in every state except IDLE, HALT and FAULT.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT; sticky until reset.
- fault_code  out  2  01 = memory timeout, 10 = illegal instruction.

## Operation
- States (3-bit): IDLE, FETCH, DECODE, OPERAND, MEM, WB, HALT, FAULT.
- Reset values:
  - state=IDLE, pc=RESET_PC, IR=OPR=ld_data=0.
  - run_q=0, wait counter=0.
  - All outputs 0 except mem_addr=pc and opcode/operand=0.
- IDLE: a run rising edge (run=1, run_q=0) moves to FETCH.
- FETCH: mem_req=1, mem_we=0. On mem_ready: IR<=mem_rdata, pc<=pc+1, go to DECODE.
- DECODE (one cycle, decoder outputs valid), first match wins:
  - dec_halt -> HALT.
  - dec_kind≠00 with dec_two_byte=0 -> FAULT, code 10.
  - dec_two_byte -> OPERAND.
  - otherwise -> WB.
- OPERAND: read at pc. On mem_ready: OPR<=mem_rdata and pc<=pc+1, then by dec_kind:
  - 00 -> WB.
  - 01 -> MEM.
  - 10 -> MEM.
  - 11 -> pc<=mem_rdata[PC_WIDTH-1:0] (overrides the increment), go to FETCH.
- MEM: mem_addr=OPR[PC_WIDTH-1:0], mem_we=(dec_kind==10). On mem_ready:
  - LOAD: ld_data<=mem_rdata, go to WB.
  - STORE: go to FETCH.
- WB (one cycle): reg_we=dec_dest_flag, wb_src=(dec_kind==01), then FETCH.
- HALT: pc already points past the HALT instruction. A run rising edge resumes at FETCH.
- FAULT: terminal. Only rst exits. fault_code holds its value.
- Wait counter:
  - Cleared on entry to every memory state and on each completed access.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - When the TIMEOUT-th consecutive wait cycle ends with mem_ready still 0: FAULT, code 01.
- Arithmetic: pc wraps modulo 2^PC_WIDTH (all-ones + 1 = 0). Operand upper bits beyond PC_WIDTH are ignored for addressing.

## Timing
- Memory handshake:
  - mem_addr and mem_we are stable while mem_req=1 until the cycle with mem_ready=1.
  - The transfer completes at that clock edge.
  - Back-to-back requests (MEM store -> FETCH) keep mem_req high with the new address.
- Cycle counts with zero wait-states:
  - ALU/MOV: 3 (FETCH, DECODE, WB).
  - ALU immediate: 4.
  - LOAD: 5.
  - STORE: 4.
  - JUMP: 3.
  - Each wait cycle adds 1.
- reg_we is high for exactly one cycle per writeback instruction and is never asserted outside WB.
- run edges arriving outside IDLE/HALT are ignored. run_q updates every cycle.
- rst mid-access drops mem_req, mem_we and reg_we immediately (asynchronously) and restarts in IDLE.

## Test plan
- Reset, run pulse, mem[0]=MOV_A_B with zero wait -> FETCH/DECODE/WB in 3 cycles; reg_we=0001 for one cycle; pc=1.
- LOAD at mem[0..1] (operand 0x0A), mem[10]=0x5C, 2 wait cycles on the data access -> ld_data=0x5C, wb_src=1, reg_we=dest, 7 cycles total.
- JUMP operand 0x03 placed at pc=14,15 -> pc=3 (not wrapped 0); plain fetch at pc=15 -> pc wraps to 0.
- mem_ready held low -> FAULT after exactly TIMEOUT=15 wait cycles; fault_code=01; run pulses ignored; rst clears.
- HALT at pc=2 -> halted=1, pc=3; run held high, no resume; run low then high -> FETCH at 3.
- STORE class with dec_two_byte=0 -> FAULT, code 10, with no mem_we pulse; separately, rst asserted mid-FETCH -> mem_req=0 immediately and state=IDLE.
